// File: rtl/clock_disp_pkg.sv
// Shared types, segment codes and the double-dabble step for the clock display reader.
package clock_disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned BCD_W      = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONV_SS = 3'd1,
    ST_CONV_MM = 3'd2,
    ST_CONV_HH = 3'd3,
    ST_COMMIT  = 3'd4
  } state_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
    logic oor;
  } field_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_code(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // One shift-add-3 iteration over {hundreds,tens,units}, shifting b in at the LSB.
  function automatic logic [11:0] dd_step(input logic [11:0] acc, input logic b);
    logic [11:0] adj;
    adj = acc;
    for (int i = 0; i < 3; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
    return {adj[10:0], b};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 8-bit binary to 3-digit BCD converter; done pulses 8 cycles after start.
module bin2bcd_seq
  import clock_disp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output bcd_t       hundreds,
  output bcd_t       tens,
  output bcd_t       units
);

  logic [11:0] acc;
  logic [7:0]  sh;
  logic [2:0]  cnt;
  logic        run;

  // The start cycle performs the first iteration directly from bin.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= 12'd0;
      sh   <= 8'd0;
      cnt  <= 3'd0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc <= dd_step(12'd0, bin[7]);
        sh  <= {bin[6:0], 1'b0};
        cnt <= 3'd1;
        run <= 1'b1;
      end else if (run) begin
        acc <= dd_step(acc, sh[7]);
        sh  <= {sh[6:0], 1'b0};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign hundreds = acc[11:8];
  assign tens     = acc[7:4];
  assign units    = acc[3:0];

endmodule

// File: rtl/clock_disp_scan.sv
// Samples hh/mm/ss/pm, converts to BCD sequentially and scans a 6-digit common-anode display.
module clock_disp_scan
  import clock_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  output logic       busy,
  output logic       bcd_valid,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t      state, state_next;
  logic [2:0]  cyc, cyc_next;
  logic        conv_start_c;
  logic [7:0]  conv_bin_c;
  logic        conv_done;
  bcd_t        conv_hund, conv_tens, conv_units;
  field_t      conv_field_c;

  logic [7:0]  sh_hh, sh_mm, sh_ss;
  logic        sh_pm;
  field_t      st_ss, st_mm;
  field_t      disp_ss, disp_mm, disp_hh;
  logic        disp_pm;

  logic [PW-1:0] presc;
  logic [2:0]    idx;

  bin2bcd_seq u_bin2bcd (
    .clk      (clk),
    .reset    (reset),
    .start    (conv_start_c),
    .bin      (conv_bin_c),
    .done     (conv_done),
    .hundreds (conv_hund),
    .tens     (conv_tens),
    .units    (conv_units)
  );

  assign conv_field_c = '{tens: conv_tens, units: conv_units, oor: (conv_hund != 4'd0)};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cyc   <= 3'd0;
    end else begin
      state <= state_next;
      cyc   <= cyc_next;
    end
  end

  // Each CONV state spans 8 cycles and kicks the converter on its first cycle.
  always_comb begin
    state_next   = state;
    cyc_next     = 3'd0;
    conv_start_c = 1'b0;
    conv_bin_c   = sh_ss;
    case (state)
      ST_IDLE: begin
        if (load) state_next = ST_CONV_SS;
      end
      ST_CONV_SS: begin
        conv_bin_c   = sh_ss;
        conv_start_c = (cyc == 3'd0);
        cyc_next     = cyc + 3'd1;
        if (cyc == 3'd7) state_next = ST_CONV_MM;
      end
      ST_CONV_MM: begin
        conv_bin_c   = sh_mm;
        conv_start_c = (cyc == 3'd0);
        cyc_next     = cyc + 3'd1;
        if (cyc == 3'd7) state_next = ST_CONV_HH;
      end
      ST_CONV_HH: begin
        conv_bin_c   = sh_hh;
        conv_start_c = (cyc == 3'd0);
        cyc_next     = cyc + 3'd1;
        if (cyc == 3'd7) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // A field result appears with done in the first cycle of the following state.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
      sh_hh     <= 8'd0;
      sh_mm     <= 8'd0;
      sh_ss     <= 8'd0;
      sh_pm     <= 1'b0;
      st_ss     <= '0;
      st_mm     <= '0;
      disp_ss   <= '0;
      disp_mm   <= '0;
      disp_hh   <= '0;
      disp_pm   <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      if (state == ST_IDLE && load) begin
        sh_hh <= hh;
        sh_mm <= mm;
        sh_ss <= ss;
        sh_pm <= pm;
      end
      if (conv_done && state == ST_CONV_MM) st_ss <= conv_field_c;
      if (conv_done && state == ST_CONV_HH) st_mm <= conv_field_c;
      if (state == ST_COMMIT) begin
        disp_ss   <= st_ss;
        disp_mm   <= st_mm;
        disp_hh   <= conv_field_c;
        disp_pm   <= sh_pm;
        bcd_valid <= 1'b1;
      end
    end
  end

  // Free-running digit scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= 3'd0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    bcd_t cur_d;
    logic cur_oor;
    logic cur_blank;
    cur_d     = 4'd0;
    cur_oor   = 1'b0;
    cur_blank = 1'b0;
    an        = ~(NUM_DIGITS'(1) << idx);
    case (idx)
      3'd0: begin cur_d = disp_ss.units; cur_oor = disp_ss.oor; end
      3'd1: begin cur_d = disp_ss.tens;  cur_oor = disp_ss.oor; end
      3'd2: begin cur_d = disp_mm.units; cur_oor = disp_mm.oor; end
      3'd3: begin cur_d = disp_mm.tens;  cur_oor = disp_mm.oor; end
      3'd4: begin cur_d = disp_hh.units; cur_oor = disp_hh.oor; end
      3'd5: begin
        cur_d     = disp_hh.tens;
        cur_oor   = disp_hh.oor;
        cur_blank = (disp_hh.tens == 4'd0);
      end
      default: begin end
    endcase
    seg = SEG_BLANK;
    if (bcd_valid) begin
      if (cur_oor)        seg = SEG_DASH;
      else if (cur_blank) seg = SEG_BLANK;
      else                seg = seg_code(cur_d);
    end
    dp = ~(bcd_valid & (idx == 3'd0) & disp_pm);
  end

endmodule

// File: tb/tb_clock_disp_scan.sv
// Scoreboard bench for clock_disp_scan: latency, decode, blanking, range, abort and scan timing.
module tb_clock_disp_scan;

  logic       clk = 1'b0;
  logic       reset, load, pm;
  logic [7:0] hh, mm, ss;
  logic       busy, bcd_valid, dp;
  logic [5:0] an;
  logic [6:0] seg;
  logic       busy3, bcd_valid3, dp3;
  logic [5:0] an3;
  logic [6:0] seg3;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [41:0] segs;
    logic [5:0]  dps;
  } exp_t;
  exp_t sb[$];

  logic [6:0] code_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  clock_disp_scan #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load), .hh(hh), .mm(mm), .ss(ss), .pm(pm),
    .busy(busy), .bcd_valid(bcd_valid), .an(an), .seg(seg), .dp(dp)
  );

  clock_disp_scan #(.SCAN_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .load(load), .hh(hh), .mm(mm), .ss(ss), .pm(pm),
    .busy(busy3), .bcd_valid(bcd_valid3), .an(an3), .seg(seg3), .dp(dp3)
  );

  function automatic exp_t model(input logic [7:0] h, input logic [7:0] m,
                                 input logic [7:0] s, input logic p);
    exp_t e;
    int   v, dig;
    logic [6:0] c;
    for (int i = 0; i < 6; i++) begin
      v = (i < 2) ? int'(s) : (i < 4) ? int'(m) : int'(h);
      dig = (i % 2 == 1) ? v / 10 : v % 10;
      if (v > 99)                  c = 7'h3F;
      else if (i == 5 && dig == 0) c = 7'h7F;
      else                         c = code_tab[dig];
      e.segs[i*7 +: 7] = c;
      e.dps[i] = !(i == 0 && p);
    end
    return e;
  endfunction

  task automatic run_conv(input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s, input logic p, input bit disturb);
    @(negedge clk);
    hh = h; mm = m; ss = s; pm = p; load = 1'b1;
    sb.push_back(model(h, m, s, p));
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_cycle N+%0d: busy=%b required 1", c, busy);
      end
      load = disturb && (c == 5 || c == 25);
      if (disturb) begin
        hh = 8'($urandom_range(1, 12));
        mm = 8'($urandom_range(0, 59));
        ss = 8'($urandom_range(0, 59));
        pm = ~p;
      end
    end
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (busy !== 1'b0 || bcd_valid !== 1'b1) begin
      failures++;
      $display("FAIL done_N+26: busy=%b bcd_valid=%b required busy=0 bcd_valid=1", busy, bcd_valid);
    end
  endtask

  task automatic check_display();
    exp_t e;
    logic [5:0] ea;
    int t;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: size=0 required >0");
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 6; i++) begin
      ea = ~(6'b000001 << i);
      t = 0;
      while (an !== ea && t < 40) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (an !== ea) begin
        failures++;
        $display("FAIL digit%0d_select_timeout: an=%b required %b", i, an, ea);
      end else begin
        if (seg !== e.segs[i*7 +: 7]) begin
          failures++;
          $display("FAIL digit%0d_seg: seg=%h required %h", i, seg, e.segs[i*7 +: 7]);
        end
        checks++;
        if (dp !== e.dps[i]) begin
          failures++;
          $display("FAIL digit%0d_dp: dp=%b required %b", i, dp, e.dps[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (an !== 6'b111110 || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0 || bcd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: an=%b seg=%h dp=%b busy=%b valid=%b required 111110 7f 1 0 0",
               an, seg, dp, busy, bcd_valid);
    end
    checks++;
    if (an3 !== 6'b111110 || seg3 !== 7'h7F || dp3 !== 1'b1 || busy3 !== 1'b0 || bcd_valid3 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state_div3: an=%b seg=%h dp=%b busy=%b valid=%b required 111110 7f 1 0 0",
               an3, seg3, dp3, busy3, bcd_valid3);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 6'b111110) begin
      failures++;
      $display("FAIL prescaler_hold: an=%b required 111110", an);
    end
    @(negedge clk);
    checks++;
    if (an !== 6'b111101) begin
      failures++;
      $display("FAIL prescaler_advance: an=%b required 111101", an);
    end
  endtask

  task automatic test_basic();
    run_conv(8'd12, 8'd34, 8'd56, 1'b1, 1'b0);
    check_display();
  endtask

  task automatic test_blank();
    run_conv(8'd6, 8'd0, 8'd9, 1'b0, 1'b0);
    check_display();
  endtask

  task automatic test_ignore_busy();
    run_conv(8'd7, 8'd8, 8'd9, 1'b1, 1'b1);
    check_display();
  endtask

  task automatic test_range();
    run_conv(8'd11, 8'd45, 8'd150, 1'b0, 1'b0);
    check_display();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    hh = 8'd10; mm = 8'd20; ss = 8'd30; pm = 1'b1; load = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      load = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || bcd_valid !== 1'b0 || seg !== 7'h7F || dp !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_conv: busy=%b valid=%b seg=%h dp=%b required 0 0 7f 1",
               busy, bcd_valid, seg, dp);
    end
    run_conv(8'd9, 8'd59, 8'd0, 1'b1, 1'b0);
    check_display();
  endtask

  task automatic test_scan();
    logic [5:0] ea;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      ea = ~(6'b000001 << ((k / 3) % 6));
      checks++;
      if (an3 !== ea) begin
        failures++;
        $display("FAIL scan_k%0d: an=%b required %b", k, an3, ea);
      end
      checks++;
      if ($countones(~an3) != 1) begin
        failures++;
        $display("FAIL scan_onehot_k%0d: an=%b required one zero bit", k, an3);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; pm = 1'b0;
    hh = 8'd0; mm = 8'd0; ss = 8'd0;
    test_reset();
    test_basic();
    test_blank();
    test_ignore_busy();
    test_range();
    test_reset_mid();
    test_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
